ibuf_pingpong: RTL and testbench

Double-buffered, banked input buffer: the next generation of the single-half input buffer. A DDR-side stream fills one half while the systolic array reads the other half through per-bank addresses. The halves swap under an explicit fill/release handshake. It sits between the DDR read path and the array's input-activation ports, and it generalises row width: one row may span several DDR beats.

---
 rtl/ibuf_pingpong_if.sv | 32 +++
 rtl/ibuf_pingpong.sv | 140 ++++++++++++++
 tb/tb_ibuf_pingpong.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_pingpong_if.sv
// Handshake and data bundle between the DDR fill path, the ping-pong input buffer
// and the array read lanes.
interface ibuf_pingpong_if #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 64,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6
);
    logic                             wr_start;
    logic [ADDR_WIDTH:0]              wr_num_rows;
    logic                             wr_start_ready;
    logic                             wr_valid;
    logic                             wr_ready;
    logic [DDR_BANDWIDTH-1:0]         wr_data;
    logic                             wr_done;
    logic                             rd_tile_valid;
    logic                             rd_release;
    logic [NUM_BANKS-1:0]             rd_req;
    logic [NUM_BANKS*ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0]  rd_data;
    logic [NUM_BANKS-1:0]             rd_valid;

    modport master (
        output wr_start, wr_num_rows, wr_valid, wr_data, rd_release, rd_req, rd_addr,
        input  wr_start_ready, wr_ready, wr_done, rd_tile_valid, rd_data, rd_valid
    );

    modport slave (
        input  wr_start, wr_num_rows, wr_valid, wr_data, rd_release, rd_req, rd_addr,
        output wr_start_ready, wr_ready, wr_done, rd_tile_valid, rd_data, rd_valid
    );
endinterface

// File: rtl/ibuf_pingpong.sv
// Double-buffered banked input buffer: DDR beats fill one half while the array
// reads the other half per bank; halves swap on fill-complete / release.
module ibuf_pingpong #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 64,
    parameter int DATA_WIDTH    = 8,
    parameter int BANK_DEPTH    = 64,
    parameter int ADDR_WIDTH    = 6
) (
    input  logic           clk,
    input  logic           reset,
    ibuf_pingpong_if.slave bus
);
    localparam int E   = DDR_BANDWIDTH / DATA_WIDTH;
    localparam int BPR = (NUM_BANKS * DATA_WIDTH) / DDR_BANDWIDTH;
    localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(BANK_DEPTH);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            full_q, full_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] last_row_q, last_row_d;
    logic                  wr_done_q;
    logic                  start_acc, beat_acc, beat_last, fill_last, release_acc;
    logic [NUM_BANKS-1:0]  rd_en_p0;
    logic [NUM_BANKS-1:0]  rd_vld_p1;

    // Zero or oversize row requests mean a full half.
    function automatic logic [ADDR_WIDTH-1:0] last_row_of(input logic [ADDR_WIDTH:0] n);
        if (n == '0 || n > DEPTH_N)
            return ADDR_WIDTH'(BANK_DEPTH - 1);
        return ADDR_WIDTH'(n - (ADDR_WIDTH+1)'(1));
    endfunction

    assign bus.wr_ready       = (state_q == FILL);
    assign bus.wr_start_ready = (state_q == IDLE) && !full_q[wr_ptr_q];
    assign bus.rd_tile_valid  = full_q[rd_ptr_q];
    assign bus.wr_done        = wr_done_q;
    assign bus.rd_valid       = rd_vld_p1;

    assign start_acc   = bus.wr_start && bus.wr_start_ready;
    assign beat_acc    = bus.wr_valid && bus.wr_ready;
    assign beat_last   = (beat_q == BW'(BPR - 1));
    assign fill_last   = beat_acc && beat_last && (row_q == last_row_q);
    assign release_acc = bus.rd_release && bus.rd_tile_valid;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        row_d      = row_q;
        last_row_d = last_row_q;
        full_d     = full_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d    = FILL;
                    beat_d     = '0;
                    row_d      = '0;
                    last_row_d = last_row_of(bus.wr_num_rows);
                end
            end
            FILL: begin
                if (beat_acc) begin
                    if (beat_last) begin
                        beat_d = '0;
                        row_d  = row_q + ADDR_WIDTH'(1);
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                    if (fill_last) begin
                        state_d          = IDLE;
                        full_d[wr_ptr_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A filling half is never full, so this cannot collide with the set above.
        if (release_acc)
            full_d[rd_ptr_q] = 1'b0;
    end

    // p0 -> p1: read request accepted against the pre-release read pointer
    assign rd_en_p0 = bus.rd_req & {NUM_BANKS{bus.rd_tile_valid}};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            full_q     <= '0;
            beat_q     <= '0;
            row_q      <= '0;
            last_row_q <= '0;
            wr_done_q  <= 1'b0;
            rd_vld_p1  <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            beat_q     <= beat_d;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            wr_done_q  <= fill_last;
            rd_vld_p1  <= rd_en_p0;
            if (fill_last)
                wr_ptr_q <= ~wr_ptr_q;
            if (release_acc)
                rd_ptr_q <= ~rd_ptr_q;
        end
    end

    for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [2*BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q_p1;
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  wen;

        assign raddr = bus.rd_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
        // Bank n belongs to beat n/E of a row, lane n%E of that beat.
        assign wen   = reset && beat_acc && (beat_q == BW'(n / E));

        always_ff @(posedge clk) begin
            if (wen)
                mem[{wr_ptr_q, row_q}] <= bus.wr_data[(n % E)*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk) begin
            if (!reset)
                rd_q_p1 <= '0;
            else if (rd_en_p0[n])
                rd_q_p1 <= mem[{rd_ptr_q, raddr}];
        end

        assign bus.rd_data[n*DATA_WIDTH +: DATA_WIDTH] = rd_q_p1;
    end
endmodule

// File: tb/tb_ibuf_pingpong.sv
// Self-checking bench for ibuf_pingpong: table-driven read vectors with a
// scoreboard of expected read data, plus hand-written fill/reset sequences.
`timescale 1ns/1ps
module tb_ibuf_pingpong;
    localparam int DDR_BANDWIDTH = 64;
    localparam int NUM_BANKS     = 16;
    localparam int DATA_WIDTH    = 8;
    localparam int BANK_DEPTH    = 4;
    localparam int ADDR_WIDTH    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ibuf_pingpong_if #(
        .DDR_BANDWIDTH(DDR_BANDWIDTH), .NUM_BANKS(NUM_BANKS),
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    ibuf_pingpong #(
        .DDR_BANDWIDTH(DDR_BANDWIDTH), .NUM_BANKS(NUM_BANKS), .DATA_WIDTH(DATA_WIDTH),
        .BANK_DEPTH(BANK_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] req;
        logic [1:0]  addr;
        bit          rot;      // bank n reads addr ^ (n%2) instead of addr
        bit          rel;
        logic        exp_tv;   // rd_tile_valid expected when the vector is driven
        logic [15:0] exp_vld;  // rd_valid expected one cycle later
    } rvec_t;

    typedef struct {
        logic [15:0]  vld;
        logic [127:0] data;
    } exp_t;

    rvec_t        vt [19];
    exp_t         sb [$];
    logic [7:0]   model_mem [2][4][16];
    logic [127:0] last_data;
    bit           tb_wr_ptr, tb_rd_ptr;
    int           checks   = 0;
    int           failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] beat_byte(input int pat, input int b, input int j);
        case (pat)
            0:       return 8'(16*b + j);
            1:       return 8'(8'hA0 + 8*(b%2) + j);
            default: return 8'(pat*37 + b*11 + j*3);
        endcase
    endfunction

    task automatic do_reset();
        reset           = 1'b0;
        bus.wr_start    = 1'b0;
        bus.wr_num_rows = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.rd_release  = 1'b0;
        bus.rd_req      = '0;
        bus.rd_addr     = '0;
        step();
        step();
        reset     = 1'b1;
        tb_wr_ptr = 1'b0;
        tb_rd_ptr = 1'b0;
        last_data = '0;
    endtask

    task automatic check_reset_state();
        check("rst_wr_ready",       bus.wr_ready,       1'b0);
        check("rst_wr_done",        bus.wr_done,        1'b0);
        check("rst_rd_tile_valid",  bus.rd_tile_valid,  1'b0);
        check("rst_wr_start_ready", bus.wr_start_ready, 1'b1);
        check("rst_rd_valid",       bus.rd_valid,       16'h0);
        check("rst_rd_data",        bus.rd_data,        128'h0);
    endtask

    task automatic send_beat(input int pat, input int b);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) begin
            d[j*8 +: 8] = beat_byte(pat, b, j);
            model_mem[tb_wr_ptr][b/2][(b%2)*8 + j] = d[j*8 +: 8];
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic fill(input int rows, input int pat, input logic exp_tv);
        int re;
        re = (rows == 0 || rows > BANK_DEPTH) ? BANK_DEPTH : rows;
        check("fill_start_ready", bus.wr_start_ready, 1'b1);
        bus.wr_start    = 1'b1;
        bus.wr_num_rows = 3'(rows);
        step();
        bus.wr_start = 1'b0;
        for (int b = 0; b < re*2; b++) begin
            check("fill_ready_not_done", {bus.wr_ready, bus.wr_done}, 2'b10);
            send_beat(pat, b);
        end
        check("fill_end_ready_done", {bus.wr_ready, bus.wr_done}, 2'b01);
        check("fill_tile_valid", bus.rd_tile_valid, exp_tv);
        tb_wr_ptr = ~tb_wr_ptr;
        step();
        check("wr_done_single_pulse", bus.wr_done, 1'b0);
    endtask

    task automatic rd_apply(input rvec_t v);
        exp_t e;
        check("rd_tile_valid", bus.rd_tile_valid, v.exp_tv);
        e.vld  = v.exp_vld;
        e.data = last_data;
        for (int n = 0; n < 16; n++) begin
            logic [1:0] a;
            a = v.rot ? (v.addr ^ 2'(n % 2)) : v.addr;
            bus.rd_addr[n*2 +: 2] = a;
            if (v.exp_vld[n])
                e.data[n*8 +: 8] = model_mem[tb_rd_ptr][a][n];
        end
        last_data = e.data;
        sb.push_back(e);
        bus.rd_req     = v.req;
        bus.rd_release = v.rel;
        if (v.rel && v.exp_tv)
            tb_rd_ptr = ~tb_rd_ptr;
        step();
        e = sb.pop_front();
        check("rd_valid", bus.rd_valid, e.vld);
        check("rd_data",  bus.rd_data,  e.data);
        bus.rd_req     = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            rd_apply(vt[i]);
    endtask

    initial begin
        vt[0]  = '{16'hFFFF, 2'd1, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vt[1]  = '{16'hFFFF, 2'd0, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vt[2]  = '{16'h0005, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0005};
        vt[3]  = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000};
        vt[4]  = '{16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vt[5]  = '{16'hFFFF, 2'd1, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vt[6]  = '{16'h00F0, 2'd1, 1'b0, 1'b0, 1'b1, 16'h00F0};
        vt[7]  = '{16'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        vt[8]  = '{16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vt[9]  = '{16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vt[10] = '{16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vt[11] = '{16'hFFFF, 2'd2, 1'b1, 1'b1, 1'b1, 16'hFFFF};
        vt[12] = '{16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        vt[13] = '{16'hFFFF, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[14] = '{16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[15] = '{16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[16] = '{16'hFFFF, 2'd1, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vt[17] = '{16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vt[18] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};

        do_reset();
        check_reset_state();

        // Basic fill of half 0 (2 rows) and reads, including partial rd_req
        fill(2, 0, 1'b1);
        run_vecs(0, 0);
        check("t1_bank0_row1", bus.rd_data[7:0],   8'd32);
        check("t1_bank7_row1", bus.rd_data[63:56], 8'd39);
        run_vecs(1, 3);

        // Ping-pong: fill half 1 while half 0 is being read
        fork
            fill(4, 1, 1'b1);
            run_vecs(4, 6);
        join

        // Backpressure: both halves full, third start and stray beat ignored
        check("bp_start_ready_low", bus.wr_start_ready, 1'b0);
        bus.wr_start    = 1'b1;
        bus.wr_num_rows = 3'd2;
        bus.wr_valid    = 1'b1;
        bus.wr_data     = '1;
        step();
        bus.wr_start = 1'b0;
        bus.wr_valid = 1'b0;
        check("bp_start_ignored", {bus.wr_ready, bus.wr_start_ready}, 2'b00);
        step();
        check("bp_still_idle", bus.wr_ready, 1'b0);
        run_vecs(7, 7);
        check("bp_start_ready_after_release", bus.wr_start_ready, 1'b1);
        run_vecs(8, 8);
        check("pp_bank0_half1", bus.rd_data[7:0],     8'hA0);
        check("pp_bank15_half1", bus.rd_data[127:120], 8'hAF);
        run_vecs(9, 9);

        // Row-count boundary: 0 and 7 both mean a full 4-row half
        fill(0, 2, 1'b1);
        run_vecs(10, 10);
        fill(7, 3, 1'b1);
        run_vecs(11, 12);

        // Read gating with no readable half; release ignored
        run_vecs(13, 15);

        // Mid-fill reset abandons a fill of half 1; next fill lands in half 0
        fill(1, 5, 1'b1);
        check("mf_start_ready", bus.wr_start_ready, 1'b1);
        bus.wr_start    = 1'b1;
        bus.wr_num_rows = 3'd4;
        step();
        bus.wr_start = 1'b0;
        for (int b = 0; b < 3; b++)
            send_beat(6, b);
        check("mf_filling", bus.wr_ready, 1'b1);
        do_reset();
        check_reset_state();
        fill(4, 4, 1'b1);
        run_vecs(16, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
